// File: rtl/usb_system_switch_poller.sv
// Polls the switch PIO over Avalon-MM and debounces the 18-bit sample; outputs move one cycle after readdatavalid.
// Holds avm_read through waitrequest stalls; abandons a poll with timeout_err if readdatavalid never arrives.
module usb_system_switch_poller #(
    parameter int         POLL_INTERVAL  = 50000,
    parameter int         STABLE_SAMPLES = 3,
    parameter int         RSP_TIMEOUT    = 16,
    parameter logic [1:0] SLAVE_ADDR     = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [17:0] switch_state,
    output logic        state_valid,
    output logic        change_pulse,
    output logic [17:0] changed_bits,
    output logic        timeout_err
);
    localparam int TW = $clog2(POLL_INTERVAL + 1);
    localparam int RW = $clog2(RSP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, EVAL} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [RW-1:0] rsp_cnt;
    logic [17:0]   sample;
    logic [17:0]   candidate;
    logic [3:0]    match_cnt;
    logic [3:0]    next_cnt;
    logic          accept;
    logic          unused_rdata;

    assign avm_address  = SLAVE_ADDR;
    assign unused_rdata = ^avm_readdata[31:18];

    // Run length of the candidate after this sample, saturating at the acceptance threshold.
    always_comb begin
        next_cnt = 4'd1;
        if (sample == candidate) begin
            if (match_cnt >= 4'(STABLE_SAMPLES))
                next_cnt = 4'(STABLE_SAMPLES);
            else
                next_cnt = match_cnt + 4'd1;
        end
    end

    assign accept = (next_cnt == 4'(STABLE_SAMPLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            rsp_cnt      <= '0;
            avm_read     <= 1'b0;
            sample       <= '0;
            candidate    <= '0;
            match_cnt    <= '0;
            switch_state <= '0;
            state_valid  <= 1'b0;
            change_pulse <= 1'b0;
            changed_bits <= '0;
            timeout_err  <= 1'b0;
        end else begin
            change_pulse <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!enable) begin
                        timer <= '0;
                    end else if (timer == TW'(POLL_INTERVAL - 1)) begin
                        timer    <= '0;
                        avm_read <= 1'b1;
                        state    <= REQ;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // The read stays asserted until accepted, regardless of enable.
                REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        rsp_cnt  <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (avm_readdatavalid) begin
                        sample <= avm_readdata[17:0];
                        state  <= EVAL;
                    end else if (rsp_cnt == RW'(RSP_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        rsp_cnt <= rsp_cnt + 1'b1;
                    end
                end
                EVAL: begin
                    state     <= IDLE;
                    candidate <= sample;
                    match_cnt <= next_cnt;
                    if (accept) begin
                        if (!state_valid) begin
                            switch_state <= sample;
                            state_valid  <= 1'b1;
                        end else if (sample != switch_state) begin
                            switch_state <= sample;
                            changed_bits <= switch_state ^ sample;
                            change_pulse <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_system_switch_poller.sv
`timescale 1ns/1ps
// Bench for usb_system_switch_poller: PIO slave model plus a run-length debounce reference.
module tb_usb_system_switch_poller;
    localparam int PI = 8;
    localparam int SS = 3;
    localparam int RT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [17:0] switch_state;
    logic        state_valid;
    logic        change_pulse;
    logic [17:0] changed_bits;
    logic        timeout_err;

    usb_system_switch_poller #(
        .POLL_INTERVAL (PI),
        .STABLE_SAMPLES(SS),
        .RSP_TIMEOUT   (RT),
        .SLAVE_ADDR    (2'd0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .switch_state     (switch_state),
        .state_valid      (state_valid),
        .change_pulse     (change_pulse),
        .changed_bits     (changed_bits),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave controls written only by the main sequence.
    int          stall_req  = 0;
    logic        slave_mute = 1'b0;
    logic [17:0] slave_data = '0;
    logic [17:0] late_data  = '0;
    int          late_req   = 0;
    // Slave status written only by the responder.
    int acc_cnt = 0;
    int rsp_cnt = 0;

    initial begin
        automatic int   stall_used = 0;
        automatic int   late_done  = 0;
        automatic logic pending    = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (reset) begin
                pending         = 1'b0;
                stall_used      = 0;
                avm_waitrequest = 1'b0;
            end else begin
                if (pending) begin
                    pending = 1'b0;
                    if (!slave_mute) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = {14'($urandom), slave_data};
                        rsp_cnt++;
                    end
                end else if (late_done != late_req) begin
                    late_done         = late_req;
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = {14'h3FFF, late_data};
                end
                if (avm_read) begin
                    if (stall_used < stall_req) begin
                        avm_waitrequest = 1'b1;
                        stall_used++;
                    end else begin
                        avm_waitrequest = 1'b0;
                        stall_used      = 0;
                        pending         = 1'b1;
                        acc_cnt++;
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end
        end
    end

    int   cyc = 0;
    int   rise_q[$];
    int   hi_run = 0;
    int   last_hi_run = 0;
    int   pulse_cnt = 0;
    logic prev_read = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (avm_read && !prev_read) rise_q.push_back(cyc);
        if (avm_read) hi_run++;
        else if (prev_read) begin
            last_hi_run = hi_run;
            hi_run      = 0;
        end
        prev_read = avm_read;
        if (change_pulse) pulse_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of sequence, required completion");
        $fatal(1, "watchdog expired");
    end

    // Reference: a value is accepted whenever the trailing run of identical samples reaches SS.
    logic [17:0] hist[$];
    logic [17:0] m_state   = '0;
    logic        m_valid   = 1'b0;
    logic [17:0] m_changed = '0;

    task automatic model_push(input logic [17:0] v, output logic exp_pulse);
        int run;
        hist.push_back(v);
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == v; i--) run++;
        exp_pulse = 1'b0;
        if (run >= SS) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_state = v;
            end else if (v != m_state) begin
                m_changed = m_state ^ v;
                m_state   = v;
                exp_pulse = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp_and_check(input logic [17:0] v, input int start);
        int   n;
        logic ep;
        n = 0;
        while (rsp_cnt == start && n < 200) begin
            tick();
            n++;
        end
        check("poll_response", rsp_cnt != start, 1);
        if (rsp_cnt != start) begin
            model_push(v, ep);
            tick();
            check("switch_state", switch_state, m_state);
            check("state_valid", state_valid, m_valid);
            check("change_pulse", change_pulse, ep);
            check("changed_bits", changed_bits, m_changed);
        end
    endtask

    task automatic do_poll(input logic [17:0] v);
        slave_data = v;
        wait_resp_and_check(v, rsp_cnt);
    endtask

    task automatic wait_accept();
        int a0;
        int n;
        a0 = acc_cnt;
        n  = 0;
        while (acc_cnt == a0 && n < 200) begin
            tick();
            n++;
        end
        check("read_accepted", acc_cnt != a0, 1);
    endtask

    initial begin
        int          p0, p1, base, pc0, acc0, rq0, r0, n, r;
        logic [17:0] v, cur;

        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        check("rst_switch_state", switch_state, 0);
        check("rst_state_valid", state_valid, 0);
        check("rst_change_pulse", change_pulse, 0);
        check("rst_changed_bits", changed_bits, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_avm_read", avm_read, 0);
        check("avm_address", avm_address, 0);

        // First acceptance after three identical polls, no change strobe.
        reset  = 1'b0;
        enable = 1'b1;
        base   = rise_q.size();
        repeat (3) do_poll(18'h2A5A5);
        check("first_valid", state_valid, 1);
        check("first_state", switch_state, 18'h2A5A5);
        check("first_no_pulse", change_pulse, 0);
        p0 = (rise_q.size() >= base + 3) ? rise_q[base + 1] - rise_q[base] : -1;
        p1 = (rise_q.size() >= base + 3) ? rise_q[base + 2] - rise_q[base + 1] : -1;
        check("poll_period_a", p0, PI + 3);
        check("poll_period_b", p1, PI + 3);

        // Clean change 0x1 -> 0x3.
        repeat (3) do_poll(18'h00001);
        tick();
        pc0 = pulse_cnt;
        repeat (3) do_poll(18'h00003);
        tick();
        check("chg_pulse_count", pulse_cnt - pc0, 1);
        check("chg_pulse_width", change_pulse, 0);
        check("chg_state", switch_state, 18'h00003);
        check("chg_bits", changed_bits, 18'h00002);

        // Bounce while stable at 0x1.
        repeat (3) do_poll(18'h00001);
        tick();
        pc0 = pulse_cnt;
        do_poll(18'h3);
        do_poll(18'h1);
        do_poll(18'h3);
        do_poll(18'h3);
        tick();
        check("bounce_no_early_pulse", pulse_cnt - pc0, 0);
        check("bounce_held_state", switch_state, 18'h00001);
        do_poll(18'h3);
        tick();
        check("bounce_pulse_count", pulse_cnt - pc0, 1);
        check("bounce_state", switch_state, 18'h00003);

        // Stall for five cycles, drop enable while the read is pending.
        stall_req  = 5;
        slave_data = 18'h00003;
        acc0 = acc_cnt;
        rq0  = rise_q.size();
        r0   = rsp_cnt;
        n    = 0;
        while (!avm_read && n < 50) begin
            tick();
            n++;
        end
        check("stall_read_seen", avm_read, 1);
        repeat (2) tick();
        enable = 1'b0;
        wait_resp_and_check(18'h00003, r0);
        stall_req = 0;
        repeat (40) tick();
        check("stall_read_len", last_hi_run, 6);
        check("stall_accepts", acc_cnt - acc0, 1);
        check("disabled_no_reads", rise_q.size() - rq0, 1);

        // Response timeout; debounce state must be untouched.
        enable     = 1'b1;
        slave_mute = 1'b1;
        wait_accept();
        n = 0;
        while (!timeout_err && n < 40) begin
            tick();
            n++;
        end
        check("timeout_latency", n, RT);
        tick();
        check("timeout_one_cycle", timeout_err, 0);
        check("timeout_state_kept", switch_state, m_state);
        check("timeout_valid_kept", state_valid, m_valid);
        slave_mute = 1'b0;
        do_poll(18'h00003);

        // Randomised polls biased towards runs of repeated values.
        cur = 18'h00003;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 5);
            if (r < 3)       v = cur;
            else if (r == 3) v = 18'h00001;
            else if (r == 4) v = 18'h00003;
            else             v = 18'($urandom);
            cur = v;
            do_poll(v);
        end

        // Reset while waiting for a response; a late response must be ignored.
        slave_mute = 1'b1;
        late_data  = 18'h3FFFF;
        wait_accept();
        tick();
        reset = 1'b1;
        #1;
        check("wrst_switch_state", switch_state, 0);
        check("wrst_state_valid", state_valid, 0);
        check("wrst_changed_bits", changed_bits, 0);
        check("wrst_avm_read", avm_read, 0);
        tick();
        reset = 1'b0;
        slave_mute = 1'b0;
        late_req++;
        repeat (3) tick();
        check("late_rsp_state", switch_state, 0);
        check("late_rsp_valid", state_valid, 0);
        check("late_rsp_timeout", timeout_err, 0);
        hist.delete();
        m_state   = '0;
        m_valid   = 1'b0;
        m_changed = '0;
        repeat (3) do_poll(18'h3FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_system_switch_poller.md
Name: usb_system_switch_poller

Overview:
Avalon-MM master that periodically reads the 18-bit switch PIO slave (data register at word address 0, readdata registered with one cycle of read latency) and debounces the samples. It publishes a stable switch vector, a one-cycle change strobe and a changed-bit mask to fabric logic, so consumers do not need to go through the Nios software. It sits beside the switch PIO in usb_system and connects to it through the Avalon interconnect as a pipelined master.

Parameters:
POLL_INTERVAL, 50000, idle cycles between polls; must be ≥2.
STABLE_SAMPLES, 3, consecutive identical samples required to accept a value; range 1..15.
RSP_TIMEOUT, 16, maximum cycles to wait for readdatavalid after the read is accepted.
SLAVE_ADDR, 0, 2-bit word address driven on avm_address.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  polling enable
avm_address  out  2  constant SLAVE_ADDR
avm_read  out  1  read request
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data; only bits [17:0] are used
avm_readdatavalid  in  1  read response valid
switch_state  out  18  debounced switch vector
state_valid  out  1  high once the first value has been accepted
change_pulse  out  1  one-cycle strobe when switch_state changes
changed_bits  out  18  old XOR new, captured with change_pulse, held until the next change
timeout_err  out  1  one-cycle strobe when a response times out

Behaviour:
- Reset (async, high): FSM=IDLE, timer=0, avm_read=0, switch_state=0, state_valid=0, change_pulse=0, changed_bits=0, timeout_err=0, candidate=0, match_cnt=0. avm_address is always SLAVE_ADDR.
- FSM states: IDLE, REQ, WAIT, EVAL.
- IDLE:
  - When enable=1, the timer increments each cycle.
  - When timer==POLL_INTERVAL-1, go to REQ and clear the timer.
  - When enable=0, the timer is held at 0.
- REQ:
  - avm_read=1.
  - Stay in REQ while avm_waitrequest=1; the read is never withdrawn, even if enable drops.
  - On the cycle where avm_waitrequest=0 the read is accepted. Go to WAIT, avm_read=0, and clear the response counter.
- WAIT:
  - On avm_readdatavalid=1, capture avm_readdata[17:0] into sample and go to EVAL.
  - Otherwise increment the response counter. When it reaches RSP_TIMEOUT, pulse timeout_err for one cycle, discard the poll (debounce state unchanged) and go to IDLE.
  - readdatavalid arriving while the FSM is in any state other than WAIT is ignored.
- EVAL (exactly one cycle, then IDLE):
  - If sample != candidate: candidate<=sample and match_cnt<=1.
  - Else: match_cnt<=min(match_cnt+1, STABLE_SAMPLES), saturating.
  - Acceptance occurs when the updated match_cnt==STABLE_SAMPLES (this includes STABLE_SAMPLES=1 on a new candidate).
  - On the first acceptance after reset: switch_state<=candidate value, state_valid<=1, no change_pulse.
  - On a later acceptance where the value differs from switch_state: switch_state<=value, changed_bits<=old^new, change_pulse=1 for one cycle.
  - On acceptance of a value equal to switch_state: no output change.
- Latency: outputs update on the clock edge ending the EVAL cycle, i.e. one cycle after the readdatavalid edge.
- Poll period when the slave never stalls: POLL_INTERVAL + 3 cycles (IDLE interval, REQ, WAIT with valid on its first cycle, EVAL).
- enable=0 mid-transaction: the current REQ/WAIT/EVAL sequence completes normally, then the FSM stays in IDLE. Debounce state is retained.
- enable=1 again: the timer restarts from 0.
- Reset mid-transaction: returns to reset values immediately. A response still in flight from the interconnect after reset is ignored, because the FSM is not in WAIT.

Test Plan:
- POLL_INTERVAL=8, STABLE_SAMPLES=3, slave with no stall returning 0x2A5A5 → avm_read pulses every 11 cycles; after the 3rd response, state_valid=1 and switch_state=0x2A5A5 with no change_pulse.
- Stable 0x00001, then the slave returns 0x00003 for 3 polls → exactly one change_pulse after the 3rd poll, switch_state=0x00003, changed_bits=0x00002.
- Bounce sequence 0x3, 0x1, 0x3, 0x3, 0x3 while stable at 0x1 → no pulse until the 5th poll; then switch_state=0x3.
- avm_waitrequest held high for 5 cycles → avm_read stays high for 6 cycles and is accepted once; enable dropped during the stall → the read still completes and no further read is issued.
- Slave never asserts readdatavalid, RSP_TIMEOUT=16 → timeout_err pulses 16 cycles after acceptance; switch_state unchanged; the next poll proceeds normally.
- Assert reset during WAIT with a late readdatavalid of 0x3FFFF → all outputs are 0 and state_valid=0; the late response is ignored.
